// File: rtl/dm_ctrl_if.sv
// Bundle of the pipeline MEM-stage port, the debug/loader port and the
// word-addressed data memory port that dm_ctrl arbitrates between.
interface dm_ctrl_if;
   // pipeline side
   logic        p_req;
   logic        p_we;
   logic [1:0]  p_size;
   logic        p_sext;
   logic [31:0] p_addr;
   logic [31:0] p_wdata;
   logic [31:0] p_rdata;
   logic        p_stall;
   logic        p_misalign;
   // debug side
   logic        d_req;
   logic        d_we;
   logic [9:0]  d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;
   // memory side
   logic [9:0]  dm_addr;
   logic [31:0] dm_din;
   logic        dm_wr;
   logic [31:0] dm_dout;

   // controller view
   modport slave (
      input  p_req, p_we, p_size, p_sext, p_addr, p_wdata,
      output p_rdata, p_stall, p_misalign,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ack,
      output dm_addr, dm_din, dm_wr,
      input  dm_dout
   );

   // requester / memory-model view
   modport master (
      output p_req, p_we, p_size, p_sext, p_addr, p_wdata,
      input  p_rdata, p_stall, p_misalign,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ack,
      input  dm_addr, dm_din, dm_wr,
      output dm_dout
   );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory controller: shares one word-wide memory port between the
// pipeline (with sub-word loads and read-modify-write sub-word stores)
// and a debug/loader port that is forced through after D_MAX_WAIT cycles.
module dm_ctrl #(
   parameter int D_MAX_WAIT = 4
) (
   input  logic     clk,
   input  logic     rst,
   dm_ctrl_if.slave bus
);

   localparam int WAIT_W = (D_MAX_WAIT > 0) ? $clog2(D_MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(D_MAX_WAIT);

   typedef enum logic {IDLE, MERGE} state_t;

   state_t            state, next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [9:0]        mrg_addr;
   logic [31:0]       mrg_data;
   logic              mrg_load;
   logic              d_win;
   logic              is_word;
   logic              misalign;
   logic              unused_addr_hi;

   // Lane select plus zero/sign extension for loads; size 11 acts as word.
   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane,
                                            input logic        sext);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         2'b00:   r = sext ? 32'(b) : {24'h0, b};
         2'b01:   r = sext ? 32'(h) : {16'h0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed lane of the old word with right-aligned store data.
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [31:0] wdata);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
         2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         default: r = wdata;
      endcase
      return r;
   endfunction

   assign unused_addr_hi = ^bus.p_addr[31:12];

   assign is_word  = bus.p_size[1];
   assign misalign = ((bus.p_size == 2'b01) && bus.p_addr[0]) ||
                     (is_word && (bus.p_addr[1:0] != 2'b00));
   assign d_win    = bus.d_req && (!bus.p_req || (wait_cnt == WAIT_MAX));

   // Port steering, load data return and next-state selection.
   always_comb begin
      next_state     = state;
      mrg_load       = 1'b0;
      bus.p_rdata    = 32'h0;
      bus.p_stall    = 1'b0;
      bus.p_misalign = 1'b0;
      bus.d_rdata    = 32'h0;
      bus.d_ack      = 1'b0;
      bus.dm_addr    = bus.p_addr[11:2];
      bus.dm_din     = bus.p_wdata;
      bus.dm_wr      = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (d_win) begin
                  bus.dm_addr = bus.d_addr;
                  bus.dm_din  = bus.d_wdata;
                  bus.dm_wr   = bus.d_we;
                  bus.d_ack   = 1'b1;
                  bus.d_rdata = bus.dm_dout;
                  bus.p_stall = bus.p_req;
               end else if (bus.p_req) begin
                  if (misalign) begin
                     bus.p_misalign = 1'b1;
                  end else if (!bus.p_we) begin
                     bus.p_rdata = load_ext(bus.dm_dout, bus.p_size,
                                            bus.p_addr[1:0], bus.p_sext);
                  end else if (is_word) begin
                     bus.dm_wr = 1'b1;
                  end else begin
                     bus.p_stall = 1'b1;
                     mrg_load    = 1'b1;
                     next_state  = MERGE;
                  end
               end
            end
            MERGE: begin
               bus.dm_addr = mrg_addr;
               bus.dm_din  = mrg_data;
               bus.dm_wr   = 1'b1;
               next_state  = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Debug starvation counter: counts cycles the debug request goes unserved.
   always_ff @(posedge clk) begin
      if (rst || !bus.d_req || bus.d_ack) wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)      wait_cnt <= wait_cnt + 1'b1;
   end

   // Capture address and merged word during the read half of a sub-word store.
   always_ff @(posedge clk) begin
      if (rst) begin
         mrg_addr <= '0;
         mrg_data <= '0;
      end else if (mrg_load) begin
         mrg_addr <= bus.p_addr[11:2];
         mrg_data <= merge_lane(bus.dm_dout, bus.p_size, bus.p_addr[1:0],
                                bus.p_wdata);
      end
   end

endmodule
